// File: rtl/riscv_mem_arbiter.sv
// Single-ported memory arbiter between the instruction-fetch port and the load/store
// port. One transaction outstanding at a time; data wins over fetch unless fetch has
// lost STARVE_MAX consecutive arbitrations. All outputs come straight from flops.
module riscv_mem_arbiter #(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [STV_W-1:0]    starve_q, starve_d;
    logic                sel_data_q, sel_data_d;  // current transaction belongs to data port
    logic                store_q, store_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                if_ready_q, if_ready_d;
    logic                d_ready_q, d_ready_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                busy_q, busy_d;
    logic                grant_fetch;

    // Next-state, arbitration and registered-output computation.
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        sel_data_d  = sel_data_q;
        store_d     = store_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        grant_fetch = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (if_req || d_req) begin
                    // Fetch wins only when alone or when it has been starved long enough.
                    grant_fetch = if_req && (!d_req || (starve_q == STV_W'(STARVE_MAX)));
                    state_d  = StIssue;
                    mem_en_d = 1'b1;
                    if (grant_fetch) begin
                        sel_data_d  = 1'b0;
                        store_d     = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        if_ready_d  = 1'b1;
                        starve_d    = '0;
                    end else begin
                        sel_data_d  = 1'b1;
                        store_d     = d_we;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        d_ready_d   = 1'b1;
                        if (!if_req) begin
                            starve_d = '0;
                        end else if (starve_q != STV_W'(STARVE_MAX)) begin
                            starve_d = starve_q + STV_W'(1);
                        end
                    end
                end
            end
            StIssue: begin
                state_d = StWait;
                lat_d   = LAT_W'(MEM_LAT - 1);
            end
            StWait: begin
                if (lat_q == '0) begin
                    state_d = StResp;
                    if (sel_data_q) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = store_q ? '0 : mem_rdata;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and output registers; reset drops any in-flight transaction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            lat_q       <= '0;
            starve_q    <= '0;
            sel_data_q  <= 1'b0;
            store_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            sel_data_q  <= sel_data_d;
            store_q     <= store_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign if_ready  = if_ready_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_ready   = d_ready_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Randomised bench for riscv_mem_arbiter. The reference model schedules each
// transaction as a set of expected cycle numbers (issue, response, next eligible
// sample) and applies the arbitration rules arithmetically.
module tb_riscv_mem_arbiter;

    localparam int unsigned ADDR_W     = 64;
    localparam int unsigned DATA_W     = 64;
    localparam int unsigned MEM_LAT    = 2;
    localparam int unsigned STARVE_MAX = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    riscv_mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_LAT   (MEM_LAT),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ready (if_ready),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ready  (d_ready),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    // Cycle n is the interval after the n-th rising edge.
    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Memory contents as a fixed function of address.
    function automatic logic [63:0] mem_fn(input logic [63:0] a);
        return {a[31:0] ^ 32'hC0FFEE11, a[63:32] + 32'h13579BDF};
    endfunction

    // Reference model state.
    bit          pend;
    int unsigned issue_cyc, resp_cyc, next_free;
    bit          win_d, win_we;
    logic [63:0] win_addr, win_wdata;
    int unsigned starve;
    logic [63:0] exp_if_rdata, exp_d_rdata;
    bit          want_reset;
    // Memory environment state.
    bit          mem_act;
    int unsigned mem_cyc;
    logic [63:0] mem_a;

    task automatic check_all_zero();
        check_eq("rst_mem_en", mem_en, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        check_eq("rst_if_ready", if_ready, 0);
        check_eq("rst_d_ready", d_ready, 0);
        check_eq("rst_if_rvalid", if_rvalid, 0);
        check_eq("rst_d_rvalid", d_rvalid, 0);
        check_eq("rst_if_rdata", if_rdata, 0);
        check_eq("rst_d_rdata", d_rdata, 0);
        check_eq("rst_busy", busy, 0);
    endtask

    task automatic model_reset();
        pend         = 1'b0;
        starve       = 0;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        mem_act      = 1'b0;
        next_free    = cyc + 1;
    endtask

    // One cycle: check outputs of the current cycle, run the memory, then drive
    // requests for the next edge and predict arbitration.
    task automatic step(input int unsigned pct);
        int unsigned k;
        bit          ex_issue, ex_resp;
        @(negedge clock);
        k        = cyc;
        ex_issue = pend && (k == issue_cyc);
        ex_resp  = pend && (k == resp_cyc);
        if (ex_resp) begin
            if (win_d) exp_d_rdata = win_we ? 64'd0 : mem_fn(win_addr);
            else       exp_if_rdata = mem_fn(win_addr);
        end
        check_eq("mem_en", mem_en, ex_issue);
        check_eq("if_ready", if_ready, ex_issue && !win_d);
        check_eq("d_ready", d_ready, ex_issue && win_d);
        check_eq("mem_we", mem_we, ex_issue && win_d && win_we);
        check_eq("if_rvalid", if_rvalid, ex_resp && !win_d);
        check_eq("d_rvalid", d_rvalid, ex_resp && win_d);
        check_eq("busy", busy, pend && (k >= issue_cyc) && (k <= resp_cyc));
        check_eq("if_rdata", if_rdata, exp_if_rdata);
        check_eq("d_rdata", d_rdata, exp_d_rdata);
        if (ex_issue) begin
            check_eq("mem_addr", mem_addr, win_addr);
            check_eq("mem_wdata", mem_wdata, win_d ? win_wdata : 64'd0);
        end
        if (ex_resp) pend = 1'b0;

        // Reset in the first wait cycle of an outstanding transaction.
        if (want_reset && pend && (k == issue_cyc + 1)) begin
            want_reset = 1'b0;
            reset  = 1'b1;
            if_req = 1'b0;
            d_req  = 1'b0;
            #1;
            check_all_zero();
            @(negedge clock);
            reset = 1'b0;
            model_reset();
            return;
        end

        if (mem_en === 1'b1) begin
            mem_act = 1'b1;
            mem_cyc = k;
            mem_a   = mem_addr;
        end
        if (mem_act && (k == mem_cyc + MEM_LAT)) begin
            mem_rdata = mem_fn(mem_a);
            mem_act   = 1'b0;
        end else begin
            mem_rdata = {$urandom, $urandom};
        end

        if (ex_issue) begin
            if (win_d) d_req = 1'b0;
            else       if_req = 1'b0;
        end
        if (!if_req && ($urandom_range(99) < pct)) begin
            if_req  = 1'b1;
            if_addr = {$urandom, $urandom};
        end
        if (!d_req && ($urandom_range(99) < pct)) begin
            d_req   = 1'b1;
            d_we    = 1'($urandom_range(1));
            d_addr  = {$urandom, $urandom};
            d_wdata = {$urandom, $urandom};
        end

        if (!pend && (if_req || d_req) && (k + 1 >= next_free)) begin
            if (if_req && (!d_req || starve == STARVE_MAX)) begin
                win_d = 1'b0; win_we = 1'b0; win_addr = if_addr; win_wdata = '0;
                starve = 0;
            end else begin
                win_d = 1'b1; win_we = d_we; win_addr = d_addr; win_wdata = d_wdata;
                starve = if_req ? ((starve < STARVE_MAX) ? starve + 1 : STARVE_MAX) : 0;
            end
            pend      = 1'b1;
            issue_cyc = k + 1;
            resp_cyc  = k + 2 + MEM_LAT;
            next_free = k + 4 + MEM_LAT;
        end
    endtask

    initial begin
        reset      = 1'b1;
        if_req     = 1'b0;
        if_addr    = '0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_addr     = '0;
        d_wdata    = '0;
        mem_rdata  = '0;
        want_reset = 1'b0;
        #1;
        check_all_zero();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();

        for (int i = 0; i < 300; i++) step(30);
        // Both ports requesting continuously: exercises the starvation override.
        for (int i = 0; i < 200; i++) step(100);
        want_reset = 1'b1;
        for (int i = 0; i < 200; i++) step(50);
        want_reset = 1'b1;
        for (int i = 0; i < 200; i++) step(100);
        for (int i = 0; i < 20; i++) step(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
